// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control path:
// FSM states, instruction classes, ALU ops, mux select codes and opcodes.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OPIMM   = 4'd7,
        CLS_OP      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } insn_class_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // funct7[5] means SUB only for register-register ops; OP-IMM reuses that
    // bit as immediate data, except for the SRAI shift encoding.
    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                         input logic is_reg_op);
        alu_op_t op;
        case (f3)
            3'b000:  op = (alt && is_reg_op) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory handshakes between the control FSM and memory.
// A request stays high until the matching ready; ready without a request is ignored.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  imem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output imem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction decoder: classifies the latched instruction and
// derives the datapath selections that stay constant across its execution.
module ctrl_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output insn_class_t cls,
    output logic [2:0]  imm_type,
    output alu_op_t     alu_op,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel
);

    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_unused_bits;

    assign w_funct3      = ir[14:12];
    assign w_funct7_5    = ir[30];
    assign w_unused_bits = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        cls       = CLS_ILLEGAL;
        imm_type  = IMM_I;
        alu_op    = ALU_ADD;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        wb_sel    = WB_ALU;
        case (ir[6:0])
            OPC_LUI: begin
                cls       = CLS_LUI;
                imm_type  = IMM_U;
                alu_op    = ALU_PASS_B;
                alu_b_sel = 1'b1;
            end
            OPC_AUIPC: begin
                cls       = CLS_AUIPC;
                imm_type  = IMM_U;
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
            end
            OPC_JAL: begin
                cls       = CLS_JAL;
                imm_type  = IMM_J;
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                cls       = CLS_JALR;
                alu_b_sel = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_BRANCH: begin
                cls      = CLS_BRANCH;
                imm_type = IMM_B;
                case (w_funct3)
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                cls       = CLS_LOAD;
                alu_b_sel = 1'b1;
                wb_sel    = WB_LOAD;
            end
            OPC_STORE: begin
                cls       = CLS_STORE;
                imm_type  = IMM_S;
                alu_b_sel = 1'b1;
            end
            OPC_OPIMM: begin
                cls       = CLS_OPIMM;
                alu_op    = arith_op(w_funct3, w_funct7_5, 1'b0);
                alu_b_sel = 1'b1;
            end
            OPC_OP: begin
                cls    = CLS_OP;
                alu_op = arith_op(w_funct3, w_funct7_5, 1'b1);
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch handshake, instruction register,
// per-state strobes, sticky illegal-instruction trap and retire counter.
module multicycle_ctrl
    import rv32_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus,
    input  logic                br_taken,
    output logic [31:0]         ir,
    output logic [2:0]          imm_type,
    output alu_op_t             alu_op,
    output logic                alu_a_sel,
    output logic                alu_b_sel,
    output logic [1:0]          wb_sel,
    output logic                reg_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                trap,
    output logic [31:0]         instret,
    output state_t              dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic        r_trap;
    logic [31:0] r_instret;

    insn_class_t w_cls;
    logic [2:0]  w_imm_type;
    alu_op_t     w_alu_op;
    logic        w_alu_a_sel;
    logic        w_alu_b_sel;
    logic [1:0]  w_wb_sel;

    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_reg_we;
    logic        w_pc_we;
    logic [1:0]  w_pc_sel;
    logic        w_retire;
    logic        w_sel_active;

    ctrl_decoder u_decoder (
        .ir        (r_ir),
        .cls       (w_cls),
        .imm_type  (w_imm_type),
        .alu_op    (w_alu_op),
        .alu_a_sel (w_alu_a_sel),
        .alu_b_sel (w_alu_b_sel),
        .wb_sel    (w_wb_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ir      <= NOP_INSN;
            r_trap    <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.imem_ready) begin
                r_ir <= bus.imem_rdata;
            end
            if (w_next == S_TRAP) begin
                r_trap <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_reg_we   = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = PC_PLUS4;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if (w_cls == CLS_BRANCH) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
                    w_next   = S_FETCH;
                end else if (w_cls == CLS_LOAD || w_cls == CLS_STORE) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_cls == CLS_STORE);
                if (bus.dmem_ready) begin
                    if (w_cls == CLS_STORE) begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_we = (r_ir[11:7] != 5'd0);
                w_pc_we  = 1'b1;
                if (w_cls == CLS_JAL) begin
                    w_pc_sel = PC_BRANCH;
                end else if (w_cls == CLS_JALR) begin
                    w_pc_sel = PC_ALU;
                end
                w_next = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // A retirement is any return to FETCH after the instruction was decoded.
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB);

    assign w_sel_active = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                          (r_state == S_MEM)    || (r_state == S_WB);

    // Reset kills every strobe in the same cycle so an in-flight access is abandoned.
    assign bus.imem_req = w_imem_req & ~rst;
    assign bus.dmem_req = w_dmem_req & ~rst;
    assign bus.dmem_we  = w_dmem_we  & ~rst;
    assign reg_we       = w_reg_we   & ~rst;
    assign pc_we        = w_pc_we    & ~rst;
    assign pc_sel       = w_pc_sel;

    assign imm_type  = w_sel_active ? w_imm_type  : IMM_I;
    assign alu_op    = w_sel_active ? w_alu_op    : ALU_ADD;
    assign alu_a_sel = w_sel_active ? w_alu_a_sel : 1'b0;
    assign alu_b_sel = w_sel_active ? w_alu_b_sel : 1'b0;
    assign wb_sel    = w_sel_active ? w_wb_sel    : WB_ALU;

    assign ir        = r_ir;
    assign trap      = r_trap;
    assign instret   = r_instret;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the
// FSM with hand-computed expectations, plus reset-abort and trap behaviour.
module tb_multicycle_ctrl;
    import rv32_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] ir;
    logic [2:0]  imm_type;
    alu_op_t     alu_op;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [31:0] instret;
    state_t      dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_instret;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .br_taken  (br_taken),
        .ir        (ir),
        .imm_type  (imm_type),
        .alu_op    (alu_op),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .wb_sel    (wb_sel),
        .reg_we    (reg_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .trap      (trap),
        .instret   (instret),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction in FETCH with zero wait; returns in DECODE.
    task automatic fetch(input logic [31:0] insn, input string tag);
        chk($sformatf("%s_fetch_state", tag), 32'(dbg_state), 32'(S_FETCH));
        chk($sformatf("%s_imem_req", tag), 32'(bus.imem_req), 32'd1);
        bus.imem_rdata = insn;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk($sformatf("%s_ir", tag), ir, insn);
        chk($sformatf("%s_dec_state", tag), 32'(dbg_state), 32'(S_DECODE));
    endtask

    // Runs an instruction that goes F,D,E,W and checks the WB-cycle outputs.
    task automatic run_wb(input logic [31:0] insn, input string tag,
                          input logic [1:0] e_pc_sel, input logic [1:0] e_wb,
                          input alu_op_t e_op, input logic e_a, input logic e_b,
                          input logic [2:0] e_imm, input logic e_reg_we);
        fetch(insn, tag);
        step();
        chk($sformatf("%s_exec_state", tag), 32'(dbg_state), 32'(S_EXEC));
        chk($sformatf("%s_exec_pc_we", tag), 32'(pc_we), 32'd0);
        step();
        chk($sformatf("%s_wb_state", tag), 32'(dbg_state), 32'(S_WB));
        chk($sformatf("%s_reg_we", tag), 32'(reg_we), 32'(e_reg_we));
        chk($sformatf("%s_pc_we", tag), 32'(pc_we), 32'd1);
        chk($sformatf("%s_pc_sel", tag), 32'(pc_sel), 32'(e_pc_sel));
        chk($sformatf("%s_wb_sel", tag), 32'(wb_sel), 32'(e_wb));
        chk($sformatf("%s_alu_op", tag), 32'(alu_op), 32'(e_op));
        chk($sformatf("%s_a_sel", tag), 32'(alu_a_sel), 32'(e_a));
        chk($sformatf("%s_b_sel", tag), 32'(alu_b_sel), 32'(e_b));
        chk($sformatf("%s_imm_type", tag), 32'(imm_type), 32'(e_imm));
        step();
        exp_instret = exp_instret + 32'd1;
        chk($sformatf("%s_instret", tag), instret, exp_instret);
    endtask

    task automatic run_branch(input logic taken, input logic [1:0] e_sel, input string tag);
        fetch(32'h0000_0463, tag);
        br_taken = 1'b1;
        chk($sformatf("%s_dec_pc_we", tag), 32'(pc_we), 32'd0);
        step();
        br_taken = taken;
        #1;
        chk($sformatf("%s_exec_state", tag), 32'(dbg_state), 32'(S_EXEC));
        chk($sformatf("%s_pc_we", tag), 32'(pc_we), 32'd1);
        chk($sformatf("%s_pc_sel", tag), 32'(pc_sel), 32'(e_sel));
        chk($sformatf("%s_imm_type", tag), 32'(imm_type), 32'(IMM_B));
        chk($sformatf("%s_reg_we", tag), 32'(reg_we), 32'd0);
        chk($sformatf("%s_alu_op", tag), 32'(alu_op), 32'(ALU_SUB));
        chk($sformatf("%s_b_sel", tag), 32'(alu_b_sel), 32'd0);
        step();
        br_taken = 1'b0;
        exp_instret = exp_instret + 32'd1;
        chk($sformatf("%s_back_fetch", tag), 32'(dbg_state), 32'(S_FETCH));
        chk($sformatf("%s_instret", tag), instret, exp_instret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        br_taken       = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.dmem_ready = 1'b0;
        exp_instret    = 32'd0;

        // Reset state
        step();
        step();
        chk("rst_imem_req_forced", 32'(bus.imem_req), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_FETCH));
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_instret", instret, 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", 32'(bus.imem_req), 32'd1);

        // ADDI x1,x0,5 with stray ready/rdata/br_taken outside their sampling windows
        fetch(32'h0050_0093, "addi");
        chk("addi_dec_imem_req", 32'(bus.imem_req), 32'd0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        bus.dmem_ready = 1'b1;
        br_taken       = 1'b1;
        step();
        chk("addi_exec_state", 32'(dbg_state), 32'(S_EXEC));
        chk("addi_ir_held", ir, 32'h0050_0093);
        chk("addi_exec_pc_we", 32'(pc_we), 32'd0);
        chk("addi_exec_dmem_req", 32'(bus.dmem_req), 32'd0);
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        br_taken       = 1'b0;
        step();
        chk("addi_wb_state", 32'(dbg_state), 32'(S_WB));
        chk("addi_reg_we", 32'(reg_we), 32'd1);
        chk("addi_wb_sel", 32'(wb_sel), 32'(WB_ALU));
        chk("addi_alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("addi_imm_type", 32'(imm_type), 32'(IMM_I));
        chk("addi_b_sel", 32'(alu_b_sel), 32'd1);
        chk("addi_pc_we", 32'(pc_we), 32'd1);
        chk("addi_pc_sel", 32'(pc_sel), 32'(PC_PLUS4));
        chk("addi_instret_wb", instret, 32'd0);
        step();
        exp_instret = 32'd1;
        chk("addi_instret", instret, exp_instret);
        chk("addi_back_fetch", 32'(dbg_state), 32'(S_FETCH));

        // LW x2,0(x1) with three dmem wait cycles
        fetch(32'h0000_A103, "lw");
        step();
        chk("lw_exec_alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("lw_exec_b_sel", 32'(alu_b_sel), 32'd1);
        chk("lw_exec_imm", 32'(imm_type), 32'(IMM_I));
        chk("lw_exec_dmem_req", 32'(bus.dmem_req), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lw_wait%0d_state", i), 32'(dbg_state), 32'(S_MEM));
            chk($sformatf("lw_wait%0d_req", i), 32'(bus.dmem_req), 32'd1);
            chk($sformatf("lw_wait%0d_we", i), 32'(bus.dmem_we), 32'd0);
            step();
        end
        bus.dmem_ready = 1'b1;
        #1;
        chk("lw_ready_req", 32'(bus.dmem_req), 32'd1);
        chk("lw_ready_we", 32'(bus.dmem_we), 32'd0);
        chk("lw_ready_pc_we", 32'(pc_we), 32'd0);
        step();
        bus.dmem_ready = 1'b0;
        chk("lw_wb_state", 32'(dbg_state), 32'(S_WB));
        chk("lw_wb_sel", 32'(wb_sel), 32'(WB_LOAD));
        chk("lw_reg_we", 32'(reg_we), 32'd1);
        chk("lw_pc_we", 32'(pc_we), 32'd1);
        chk("lw_wb_dmem_req", 32'(bus.dmem_req), 32'd0);
        step();
        exp_instret = exp_instret + 32'd1;
        chk("lw_instret", instret, exp_instret);

        // BEQ x0,x0,+8 taken and not taken
        run_branch(1'b1, PC_BRANCH, "beq_t");
        run_branch(1'b0, PC_PLUS4, "beq_nt");

        // rd = x0 suppresses the register write but still retires
        run_wb(32'h0000_0013, "nop", PC_PLUS4, WB_ALU, ALU_ADD, 1'b0, 1'b1, IMM_I, 1'b0);
        run_wb(32'h0080_00EF, "jal", PC_BRANCH, WB_PC4, ALU_ADD, 1'b1, 1'b1, IMM_J, 1'b1);
        run_wb(32'h0001_00E7, "jalr", PC_ALU, WB_PC4, ALU_ADD, 1'b0, 1'b1, IMM_I, 1'b1);
        run_wb(32'h1234_52B7, "lui", PC_PLUS4, WB_ALU, ALU_PASS_B, 1'b0, 1'b1, IMM_U, 1'b1);
        run_wb(32'h0000_1297, "auipc", PC_PLUS4, WB_ALU, ALU_ADD, 1'b1, 1'b1, IMM_U, 1'b1);
        run_wb(32'h4020_81B3, "sub", PC_PLUS4, WB_ALU, ALU_SUB, 1'b0, 1'b0, IMM_I, 1'b1);
        run_wb(32'h0020_B1B3, "sltu", PC_PLUS4, WB_ALU, ALU_SLTU, 1'b0, 1'b0, IMM_I, 1'b1);
        run_wb(32'h4030_D193, "srai", PC_PLUS4, WB_ALU, ALU_SRA, 1'b0, 1'b1, IMM_I, 1'b1);
        run_wb(32'hC000_8193, "addi_neg", PC_PLUS4, WB_ALU, ALU_ADD, 1'b0, 1'b1, IMM_I, 1'b1);

        // SW x2,0(x1) with zero-wait data memory
        fetch(32'h0020_A023, "sw");
        step();
        chk("sw_exec_imm", 32'(imm_type), 32'(IMM_S));
        chk("sw_exec_b_sel", 32'(alu_b_sel), 32'd1);
        chk("sw_exec_alu_op", 32'(alu_op), 32'(ALU_ADD));
        step();
        bus.dmem_ready = 1'b1;
        #1;
        chk("sw_dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("sw_dmem_we", 32'(bus.dmem_we), 32'd1);
        chk("sw_pc_we", 32'(pc_we), 32'd1);
        chk("sw_pc_sel", 32'(pc_sel), 32'(PC_PLUS4));
        chk("sw_reg_we", 32'(reg_we), 32'd0);
        step();
        bus.dmem_ready = 1'b0;
        exp_instret = exp_instret + 32'd1;
        chk("sw_back_fetch", 32'(dbg_state), 32'(S_FETCH));
        chk("sw_instret", instret, exp_instret);
        chk("sw_fetch_dmem_req", 32'(bus.dmem_req), 32'd0);

        // SW aborted by reset in its second MEM wait cycle
        fetch(32'h0020_A023, "sw_rst");
        step();
        step();
        chk("swr_wait1_req", 32'(bus.dmem_req), 32'd1);
        chk("swr_wait1_we", 32'(bus.dmem_we), 32'd1);
        chk("swr_wait1_pc_we", 32'(pc_we), 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("swr_rst_req_forced", 32'(bus.dmem_req), 32'd0);
        step();
        chk("swr_state", 32'(dbg_state), 32'(S_FETCH));
        chk("swr_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("swr_instret", instret, 32'd0);
        chk("swr_ir", ir, 32'h0000_0013);
        rst = 1'b0;
        exp_instret = 32'd0;
        #1;
        chk("swr_imem_req", 32'(bus.imem_req), 32'd1);

        // Illegal opcode: sticky trap, no strobes, no retirements
        fetch(32'h0000_0000, "ill");
        step();
        chk("ill_state", 32'(dbg_state), 32'(S_TRAP));
        chk("ill_trap", 32'(trap), 32'd1);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        br_taken       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("ill_c%0d_strobes", i),
                32'({bus.imem_req, bus.dmem_req, reg_we, pc_we}), 32'd0);
            chk($sformatf("ill_c%0d_trap", i), 32'(trap), 32'd1);
            chk($sformatf("ill_c%0d_instret", i), instret, exp_instret);
            step();
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        br_taken       = 1'b0;
        rst            = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("ill_rst_state", 32'(dbg_state), 32'(S_FETCH));
        chk("ill_rst_trap", 32'(trap), 32'd0);
        chk("ill_rst_imem_req", 32'(bus.imem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
